// File: rtl/regfile_port_seq.sv
// Register-file port sequencer: arbitrates decode operand reads and queued writebacks.
// Optional operand forwarding from the writeback FIFO: define REGSEQ_BYPASS_EN.
module regfile_port_seq #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_rs1_addr,
    input  logic [ADDR_W-1:0] rd_rs2_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] op1_data,
    output logic [DATA_W-1:0] op2_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    output logic [ADDR_W-1:0] rf_rs1_addr,
    output logic [ADDR_W-1:0] rf_rs2_addr,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_r_w,
    input  logic [DATA_W-1:0] rf_rs1_data,
    input  logic [DATA_W-1:0] rf_rs2_data
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fifo_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [WB_DEPTH];
    logic              rd_ack_q, rd_ack_d;
    logic              rf_r_w_q, rf_r_w_d;
    logic [ADDR_W-1:0] rf_rs1_addr_q, rf_rs1_addr_d;
    logic [ADDR_W-1:0] rf_rs2_addr_q, rf_rs2_addr_d;
    logic [ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [DATA_W-1:0] rf_rd_data_q, rf_rd_data_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;

    logic              push, pop, blocked;
    logic [CNT_W-1:0]  count_after;
    logic [PTR_W-1:0]  head_ptr, idx;
    logic [DATA_W-1:0] src1, src2;

    assign wb_ready    = (count_q != FULL);
    assign rd_ack      = rd_ack_q;
    assign rf_r_w      = rf_r_w_q;
    assign rf_rs1_addr = rf_rs1_addr_q;
    assign rf_rs2_addr = rf_rs2_addr_q;
    assign rf_rd_addr  = rf_rd_addr_q;
    assign rf_rd_data  = rf_rd_data_q;
    assign op1_data    = op1_q;
    assign op2_data    = op2_q;

    always_comb begin
        pop         = (state_q == WR);
        push        = wb_valid && wb_ready;
        count_after = count_q - CNT_W'(pop);
        head_ptr    = rd_ptr_q + PTR_W'(pop);
        blocked     = 1'b0;
        src1        = rf_rs1_data;
        src2        = rf_rs2_data;
        idx         = '0;
`ifdef REGSEQ_BYPASS_EN
        // Walk oldest to youngest so the youngest match wins.
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (fifo_addr_q[idx] == rf_rs1_addr_q) src1 = fifo_data_q[idx];
                if (fifo_addr_q[idx] == rf_rs2_addr_q) src2 = fifo_data_q[idx];
            end
        end
`else
        // The head being written this cycle no longer blocks.
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && !(pop && (i == 0)) &&
                ((fifo_addr_q[idx] == rd_rs1_addr) ||
                 (fifo_addr_q[idx] == rd_rs2_addr)))
                blocked = 1'b1;
        end
`endif

        state_d = state_q;
        unique case (state_q)
            RD: state_d = RESP;
            IDLE, RESP, WR: begin
                if (count_after == FULL)
                    state_d = WR;
                else if (rd_req && !blocked && (state_q != RESP))
                    state_d = RD;
                else if (count_after != '0)
                    state_d = WR;
                else
                    state_d = IDLE;
            end
        endcase

        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = wb_addr;
            fifo_data_d[wr_ptr_q] = wb_data;
        end
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);

        rd_ack_d      = (state_d == RESP);
        rf_r_w_d      = (state_d != WR);
        rf_rs1_addr_d = (state_d == RD) ? rd_rs1_addr : rf_rs1_addr_q;
        rf_rs2_addr_d = (state_d == RD) ? rd_rs2_addr : rf_rs2_addr_q;
        rf_rd_addr_d  = (state_d == WR) ? fifo_addr_q[head_ptr] : rf_rd_addr_q;
        rf_rd_data_d  = (state_d == WR) ? fifo_data_q[head_ptr] : rf_rd_data_q;
        op1_d         = (state_q == RD) ? src1 : op1_q;
        op2_d         = (state_q == RD) ? src2 : op2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ack_q      <= 1'b0;
            rf_r_w_q      <= 1'b1;
            rf_rs1_addr_q <= '0;
            rf_rs2_addr_q <= '0;
            rf_rd_addr_q  <= '0;
            rf_rd_data_q  <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_addr_q   <= fifo_addr_d;
            fifo_data_q   <= fifo_data_d;
            rd_ack_q      <= rd_ack_d;
            rf_r_w_q      <= rf_r_w_d;
            rf_rs1_addr_q <= rf_rs1_addr_d;
            rf_rs2_addr_q <= rf_rs2_addr_d;
            rf_rd_addr_q  <= rf_rd_addr_d;
            rf_rd_data_q  <= rf_rd_data_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
        end
    end

endmodule

// File: doc/regfile_port_seq.md
# regfile_port_seq

Register-file port sequencer for the 8-bit core: the initiator that drives the `regFile` read/write port on behalf of the decode and writeback stages. Each cycle it chooses one register-file action: an operand read for decode, or one write from a small writeback FIFO. Writes never collide with reads on the shared `r_w` line. The block sits between the decode/writeback pipeline stages and the register file.

## Interface
- `DATA_W`, 8, register width
- `ADDR_W`, 3, register index width (8 registers)
- `WB_DEPTH`, 2, writeback FIFO entries (power of two, ≥2)

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `rd_req`  in  1  decode operand-read request, level; held with addresses until `rd_ack`
- `rd_rs1_addr`, `rd_rs2_addr`  in  ADDR_W  operand indices
- `rd_ack`  out  1  one-cycle pulse; `op1_data`/`op2_data` valid in this cycle
- `op1_data`, `op2_data`  out  DATA_W  captured operands, held until next `rd_ack`
- `wb_valid`  in  1  writeback push request
- `wb_addr`  in  ADDR_W  destination index
- `wb_data`  in  DATA_W  destination data
- `wb_ready`  out  1  FIFO not full; push occurs when `wb_valid & wb_ready` at a clock edge
- `rf_rs1_addr`, `rf_rs2_addr`  out  ADDR_W  to register file
- `rf_rd_addr`  out  ADDR_W  to register file
- `rf_rd_data`  out  DATA_W  to register file
- `rf_r_w`  out  1  1 = read, 0 = write
- `rf_rs1_data`, `rf_rs2_data`  in  DATA_W  combinational read data from register file

## Operation
- States:
  - IDLE: no access, `rf_r_w=1`.
  - RD: `rf_rs*_addr` = request addresses, `rf_r_w=1`, operands captured at the closing edge.
  - RESP: `rd_ack=1`.
  - WR: FIFO head driven on `rf_rd_addr`/`rf_rd_data`, `rf_r_w=0`, head popped at the closing edge.
- Next-state decision, evaluated at the closing edge of IDLE, RESP and WR, in priority order:
  - FIFO full → WR.
  - `rd_req` and not blocked, and current state ≠ RESP → RD.
  - FIFO non-empty → WR.
  - Otherwise → IDLE.
- RD → RESP unconditionally.
- `rd_req` is ignored during RESP, so one request yields exactly one `rd_ack`.
- `rf_r_w=0` only in WR, exactly one cycle per popped entry. The register file writes whenever `r_w=0`, so there are no idle write cycles.
- FIFO: in-order; push and pop may occur in the same cycle.
- `wb_ready = (count != WB_DEPTH)`, registered count only. A full FIFO refuses a push even in a popping cycle.
- Blocked (bypass compiled out only): either request address matches any valid FIFO entry.
- With bypass: a read is never blocked. Forwarding rules are under Configuration.
- Reset: state IDLE, FIFO empty, pending writebacks discarded.
- Reset values of outputs:
  - `rd_ack=0`, `op1_data=op2_data=0`.
  - `rf_r_w=1`, `rf_*_addr=0`, `rf_rd_data=0`.
  - `wb_ready=1`.

## Timing
- Read latency, best case: `rd_req` sampled in IDLE at edge N → RD in cycle N+1 → `rd_ack` in cycle N+2.
- A full FIFO or a blocked read adds one cycle per intervening WR.
- A push accepted at edge N is eligible for WR from cycle N+1. It is visible to forwarding only from the RD cycle after edge N.
- `reset_n` low forces `rf_r_w=1` asynchronously. A write in flight is aborted and the register file is not written.

## Configuration
- `REGSEQ_BYPASS_EN` defined:
  - At RD, each operand whose index matches a valid FIFO entry takes the youngest matching entry's data instead of `rf_rs*_data`.
  - Reads are never blocked; the FIFO drains later.
- Not defined:
  - No forwarding logic.
  - A matching read stalls; WRs drain until no entry matches, then RD proceeds.
- Register-file contents after the FIFO drains are identical in both builds.

## Test plan
- Reset: hold `reset_n=0` → `rf_r_w=1`, `wb_ready=1`, `rd_ack=0`, `op1_data=op2_data=0x00`.
- Plain read: register file preset `r[i]=i`, FIFO empty, `rd_req` with rs1=3, rs2=5 sampled at edge N → `rd_ack` in cycle N+2, `op1=0x03`, `op2=0x05`.
- Writeback drain: push (2, 0xA5), no `rd_req` → exactly one cycle with `rf_r_w=0`, `rf_rd_addr=2`, `rf_rd_data=0xA5`. A subsequent read of r2 returns 0xA5.
- Hazard read: push (4, 0x5A) at edge N, then `rd_req` rs1=4, rs2=1 in cycle N+1:
  - With `REGSEQ_BYPASS_EN`: `rd_ack` in N+3, `op1=0x5A`, `op2=0x01`, WR of r4 follows.
  - Without it: WR in N+2, `rd_ack` in N+4, same operand values.
- Full backpressure: `WB_DEPTH=2`, two pushes with `rd_req` held → `wb_ready=0`, next action WR despite `rd_req`, a third `wb_valid` is not accepted until the pop.
- Reset mid-write: drop `reset_n` during WR → `rf_r_w=1` immediately, FIFO count 0, `wb_ready=1`, no `rd_ack` after release until a new request.
